// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared defaults, channel tags and helpers for the I2S transmit path
package i2s_pkg;

  // Default audio sample width, bclk cycles per lrclk half-period, input buffer depth.
  localparam int I2S_W_DEFAULT          = 24;
  localparam int I2S_SLOT_BITS_DEFAULT  = 32;
  localparam int I2S_FIFO_DEPTH_DEFAULT = 4;

  // Channel tag carried in the top bit of each input word; equals the lrclk level of its slot.
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef logic [15:0] ucount_t;

  // Saturating 16-bit increment used by the underrun statistics counter.
  function automatic ucount_t sat_inc16(input ucount_t v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// rtl/i2s_tx_fifo.sv - word buffer between the upstream stream and the I2S slot shifter
module i2s_tx_fifo #(
  parameter int DATA_W = 25,
  parameter int DEPTH  = 4
) (
  input  logic                     bclk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  // DEPTH must be a power of two and at least 2; pointers carry one wrap bit so full and
  // empty are distinguished by the pointer difference alone.
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == LEVEL_FULL);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Write pointer: advances on every accepted push; reset discards all buffered words.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer: advances when the slot logic consumes the head word.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge bclk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/send_data_to_i2s.sv
// rtl/send_data_to_i2s.sv - I2S transmitter with input word buffer; optional underrun stats via I2S_TX_UNDERRUN_EN
module send_data_to_i2s
  import i2s_pkg::*;
#(
  parameter int I2S_DATA_BIT_WIDTH = I2S_W_DEFAULT,
  parameter int SLOT_BITS          = I2S_SLOT_BITS_DEFAULT,
  parameter int FIFO_DEPTH         = I2S_FIFO_DEPTH_DEFAULT
) (
  input  logic                            bclk,
  input  logic                            rst,
  input  logic [I2S_DATA_BIT_WIDTH:0]     s_data,
  input  logic                            s_data_valid,
  output logic                            s_data_ready,
  output logic                            lrclk,
  output logic                            sdata,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  input  logic                            underrun_clr,
  output logic                            underrun,
  output logic [15:0]                     underrun_count
);

  // SLOT_BITS must be at least W+1 so the one-bclk I2S delay plus all W sample bits fit
  // inside a slot; the shifter relies on that to be empty again by the next slot edge 0.
  localparam int W  = I2S_DATA_BIT_WIDTH;
  localparam int CW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  shreg;
  logic [W:0]    head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          slot_start;
  logic          next_lr;
  logic          push;
  logic          pop;
  logic          underrun_slot;

  // The edge on which cnt wraps to 0 is slot edge 0: lrclk flips and a new word is chosen.
  assign slot_start    = (cnt == CNT_LAST);
  assign next_lr       = ~lrclk;
  assign s_data_ready  = !fifo_full;
  assign push          = s_data_valid && s_data_ready;
  // Only a head word whose tag matches the upcoming slot may leave; a mismatched head
  // waits for the next slot of its own channel and that slot goes out as silence.
  assign pop           = slot_start && !fifo_empty && (head[W] == next_lr);
  assign underrun_slot = slot_start && !pop;

  i2s_tx_fifo #(
    .DATA_W (W + 1),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .bclk      (bclk),
    .rst       (rst),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  // Slot counter and word select; reset parks just before slot edge 0 of a left slot.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      cnt   <= CNT_LAST;
      lrclk <= CH_RIGHT;
    end else if (slot_start) begin
      cnt   <= '0;
      lrclk <= next_lr;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Serializer: load at slot edge 0 (line idles that edge), then MSB first; zeros shift
  // in behind the sample so the tail of the slot stays 0 without extra compare logic.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      sdata <= 1'b0;
    end else if (slot_start) begin
      shreg <= pop ? head[W-1:0] : '0;
      sdata <= 1'b0;
    end else begin
      sdata <= shreg[W-1];
      shreg <= {shreg[W-2:0], 1'b0};
    end
  end

`ifdef I2S_TX_UNDERRUN_EN
  // Sticky underrun flag and saturating count of silent slots; a clear beats a new set.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else if (underrun_clr) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else if (underrun_slot) begin
      underrun       <= 1'b1;
      underrun_count <= sat_inc16(underrun_count);
    end
  end
`else
  // Statistics disabled: outputs held low, clear input has no effect.
  assign underrun       = 1'b0;
  assign underrun_count = '0;

  logic unused_underrun;
  assign unused_underrun = underrun_clr ^ underrun_slot;
`endif

endmodule

// File: tb/tb_send_data_to_i2s.sv
// tb/tb_send_data_to_i2s.sv - randomized scoreboard bench for send_data_to_i2s
module tb_send_data_to_i2s;

  localparam int W     = 24;
  localparam int SLOT  = 32;
  localparam int DEPTH = 4;
`ifdef I2S_TX_UNDERRUN_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  logic          bclk;
  logic          rst;
  logic [W:0]    s_data;
  logic          s_data_valid;
  logic          s_data_ready;
  logic          lrclk;
  logic          sdata;
  logic [2:0]    fifo_level;
  logic          underrun_clr;
  logic          underrun;
  logic [15:0]   underrun_count;

  send_data_to_i2s #(
    .I2S_DATA_BIT_WIDTH (W),
    .SLOT_BITS          (SLOT),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .bclk           (bclk),
    .rst            (rst),
    .s_data         (s_data),
    .s_data_valid   (s_data_valid),
    .s_data_ready   (s_data_ready),
    .lrclk          (lrclk),
    .sdata          (sdata),
    .fifo_level     (fifo_level),
    .underrun_clr   (underrun_clr),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  typedef struct {
    logic            lr;
    logic [SLOT-1:0] bits;
  } slot_t;

  int         checks = 0;
  int         errors = 0;
  int         slots_seen = 0;

  // Reference model: buffered words, position within the slot, current channel, statistics.
  logic [W:0] m_q [$];
  int         m_pos;
  logic       m_lr;
  logic       m_flag;
  int         m_ucnt;
  logic       last_acc;
  slot_t      exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_pos  = SLOT - 1;
    m_lr   = 1'b1;
    m_flag = 1'b0;
    m_ucnt = 0;
  endtask

  // Called at posedge+1: compare live state with the model, then predict the next edge.
  task automatic cycle();
    logic [W:0] word;
    logic       ur;
    slot_t      e;
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    chk("s_data_ready", 32'(s_data_ready), 32'(m_q.size() < DEPTH));
    chk("underrun", 32'(underrun), UR_EN ? 32'(m_flag) : 32'd0);
    chk("underrun_count", 32'(underrun_count), UR_EN ? 32'(m_ucnt) : 32'd0);
    last_acc = s_data_valid && (m_q.size() < DEPTH);
    ur = 1'b0;
    if (m_pos == SLOT - 1) begin
      m_pos = 0;
      m_lr  = ~m_lr;
      word  = '0;
      if (m_q.size() > 0 && m_q[0][W] == m_lr) word = m_q.pop_front();
      else ur = 1'b1;
      e.lr   = m_lr;
      e.bits = '0;
      for (int k = 1; k <= W; k++) e.bits[k] = word[W-k];
      exp_q.push_back(e);
    end else begin
      m_pos++;
    end
    if (underrun_clr) begin
      m_flag = 1'b0;
      m_ucnt = 0;
    end else if (ur) begin
      m_flag = 1'b1;
      if (m_ucnt < 65535) m_ucnt++;
    end
    if (last_acc) m_q.push_back(s_data);
    @(posedge bclk);
    #1;
  endtask

  // Monitor: rebuild each slot from the line and compare against the expected slot queue.
  int              mk = -1;
  logic            prev_lr = 1'b1;
  logic            have_cur = 1'b0;
  logic [SLOT-1:0] got;
  slot_t           cur;

  always @(negedge bclk) begin
    if (!rst) begin
      mk       = -1;
      prev_lr  = 1'b1;
      have_cur = 1'b0;
    end else begin
      if (lrclk !== prev_lr) begin
        if (mk >= 0) chk("slot_length", 32'(mk), 32'(SLOT - 1));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          have_cur = 1'b0;
          $display("FAIL slot_unexpected: lrclk toggled with no slot predicted at %0t", $time);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          chk("lrclk", 32'(lrclk), 32'(cur.lr));
        end
        mk     = 0;
        got    = '0;
        got[0] = sdata;
      end else if (mk >= 0) begin
        mk++;
        if (mk < SLOT) got[mk] = sdata;
        else if (mk == SLOT) chk("slot_overrun", 32'(mk), 32'(SLOT - 1));
      end
      if (mk == SLOT - 1 && have_cur) begin
        chk("slot_bits", got, cur.bits);
        slots_seen++;
        have_cur = 1'b0;
      end
      prev_lr = lrclk;
    end
  end

  logic alt;
  logic found;

  initial begin
    s_data       = '0;
    s_data_valid = 1'b0;
    underrun_clr = 1'b0;
    rst          = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_async_lrclk", 32'(lrclk), 32'd1);
    chk("rst_async_sdata", 32'(sdata), 32'd0);
    chk("rst_async_level", 32'(fifo_level), 32'd0);
    chk("rst_async_ready", 32'(s_data_ready), 32'd1);
    chk("rst_async_underrun", 32'(underrun), 32'd0);
    chk("rst_async_count", 32'(underrun_count), 32'd0);
    repeat (3) @(posedge bclk);
    #1;
    chk("rst_hold_lrclk", 32'(lrclk), 32'd1);

    // Directed: left A5A5A5 then right 5A5A5A right after release.
    rst = 1'b1;
    s_data_valid = 1'b1;
    s_data = {1'b0, 24'hA5A5A5};
    cycle();
    s_data = {1'b1, 24'h5A5A5A};
    cycle();
    s_data_valid = 1'b0;
    repeat (4 * SLOT) cycle();

    // Idle line: every slot silent, then a clear pulse.
    repeat (3 * SLOT) cycle();
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    repeat (SLOT) cycle();

    // Back-pressure: valid held high with random tags, buffer fills and drains.
    s_data_valid = 1'b1;
    s_data = {1'($urandom_range(0, 1)), W'($urandom)};
    repeat (10 * SLOT) begin
      cycle();
      if (last_acc) s_data = {1'($urandom_range(0, 1)), W'($urandom)};
    end
    s_data_valid = 1'b0;

    // Alternating-tag random words with random gaps; start with a right word.
    alt = 1'b1;
    repeat (12 * SLOT) begin
      if (!s_data_valid && $urandom_range(0, 3) != 0) begin
        s_data = {alt, W'($urandom)};
        s_data_valid = 1'b1;
      end
      cycle();
      if (last_acc) begin
        alt = ~alt;
        s_data_valid = 1'b0;
      end
    end

    // Reset at slot edge 10 of a right slot while words are buffered and a push is offered.
    s_data_valid = 1'b1;
    s_data = {1'($urandom_range(0, 1)), W'($urandom)};
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_lr == 1'b1 && m_pos == 10) found = 1'b1;
      else begin
        cycle();
        if (last_acc) s_data = {1'($urandom_range(0, 1)), W'($urandom)};
      end
    end
    chk("reach_right_edge10", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    chk("midslot_rst_lrclk", 32'(lrclk), 32'd1);
    chk("midslot_rst_sdata", 32'(sdata), 32'd0);
    chk("midslot_rst_level", 32'(fifo_level), 32'd0);
    chk("midslot_rst_ready", 32'(s_data_ready), 32'd1);
    model_reset();
    s_data_valid = 1'b0;
    repeat (3) @(posedge bclk);
    #1;
    rst = 1'b1;

    alt = 1'b0;
    repeat (6 * SLOT) begin
      if (!s_data_valid && $urandom_range(0, 2) != 0) begin
        s_data = {alt, W'($urandom)};
        s_data_valid = 1'b1;
      end
      cycle();
      if (last_acc) begin
        alt = ~alt;
        s_data_valid = 1'b0;
      end
    end
    s_data_valid = 1'b0;

    chk("slots_compared", 32'(slots_seen >= 30), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
